// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Generic N-stage in-order pipeline sequencer. Drives stage enables
//            and load strobes, owns the fetch PC, handles redirects from the
//            flush stage and stalls issue on RAW/WAW hazards through a
//            one-bit-per-register pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int                 N_STAGES       = 4,
  parameter int                 M_WIDTH        = 32,
  parameter int                 REG_CNT        = 32,
  parameter int                 REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int                 ISSUE_STAGE    = 2,
  parameter int                 FLUSH_STAGE    = 2,
  parameter int                 INST_BYTES     = 4,
  parameter logic [M_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_STAGES-1:0]       stage_ready,
  output logic [N_STAGES-1:0]       stage_en,
  output logic [N_STAGES-1:0]       stage_load,
  output logic [M_WIDTH-1:0]        pc,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic [1:0]                issue_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_rd_wr,
  input  logic [REG_ADDR_WIDTH-1:0] retire_rd,
  input  logic                      retire_wr,
  input  logic                      flush,
  input  logic [M_WIDTH-1:0]        flush_pc,
  output logic                      hazard_stall
);

  // Reject stage configurations where the flush point lies outside the
  // fetch..issue window; the kill and hazard logic rely on that ordering.
  if (!(FLUSH_STAGE >= 1 && FLUSH_STAGE <= ISSUE_STAGE && ISSUE_STAGE < N_STAGES)) begin : g_bad_cfg
    $error("pipe_ctrl: require 1 <= FLUSH_STAGE <= ISSUE_STAGE < N_STAGES");
  end

  logic [N_STAGES-1:0] stage_en_q, stage_en_d;
  logic [M_WIDTH-1:0]  pc_q, pc_d;
  logic [REG_CNT-1:0]  pending_q, pending_d;

  logic [N_STAGES-1:0] st_complete;
  logic                fetch_idle;
  logic [N_STAGES-1:0] load_raw;
  logic [N_STAGES-1:0] load;
  logic [REG_CNT-1:0]  pend_eff;
  logic                retire_ev;
  logic                hazard;
  logic                flush_take;

  // Per-stage status decode from {en, ready}
  always_comb begin
    st_complete = stage_en_q & stage_ready;
    fetch_idle  = !stage_en_q[0] && !stage_ready[0];
    retire_ev   = rst && st_complete[N_STAGES-1] && retire_wr && (retire_rd != '0);
  end

  // Effective pending view: a same-cycle retire releases its register early
  always_comb begin
    pend_eff = pending_q;
    if (retire_ev) begin
      pend_eff[retire_rd] = 1'b0;
    end
    pend_eff[0] = 1'b0;
  end

  // Issue hazard check on the instruction waiting in the stage before issue
  always_comb begin
    hazard = rst && st_complete[ISSUE_STAGE-1] &&
             ((issue_rs_used[0] && pend_eff[issue_rs1]) ||
              (issue_rs_used[1] && pend_eff[issue_rs2]) ||
              (issue_rd_wr      && pend_eff[issue_rd]));
  end

  // Load strobes before the flush kill is applied
  always_comb begin
    load_raw    = '0;
    load_raw[0] = rst && fetch_idle;
    for (int k = 1; k < N_STAGES; k++) begin
      load_raw[k] = rst && st_complete[k-1] && !stage_en_q[k] &&
                    !((k == ISSUE_STAGE) && hazard);
    end
  end

  // A redirect is taken only when the flushing instruction actually moves on
  if (FLUSH_STAGE == N_STAGES - 1) begin : g_flush_last
    assign flush_take = rst && flush && st_complete[FLUSH_STAGE];
  end else begin : g_flush_mid
    assign flush_take = rst && flush && st_complete[FLUSH_STAGE] && load_raw[FLUSH_STAGE+1];
  end

  // Final load strobes: younger stages hold off while a redirect is taken
  always_comb begin
    load = load_raw;
    if (flush_take) begin
      load[FLUSH_STAGE:0] = '0;
    end
  end

  // Next-state for enables, PC and scoreboard
  always_comb begin
    stage_en_d = stage_en_q;
    if (st_complete[N_STAGES-1]) begin
      stage_en_d[N_STAGES-1] = 1'b0;
    end
    for (int k = N_STAGES - 1; k >= 1; k--) begin
      if (load[k]) begin
        stage_en_d[k-1] = 1'b0;
      end
    end
    if (flush_take) begin
      stage_en_d[FLUSH_STAGE-1:0] = '0;
    end
    // A stage that both hands off and reloads ends up enabled
    for (int k = 0; k < N_STAGES; k++) begin
      if (load[k]) begin
        stage_en_d[k] = 1'b1;
      end
    end

    pc_d = pc_q;
    if (flush_take) begin
      pc_d = flush_pc;
    end else if (load[1]) begin
      pc_d = pc_q + M_WIDTH'(INST_BYTES);
    end

    // Clear before set so a same-cycle retire and reissue leaves the bit set
    pending_d = pending_q;
    if (retire_ev) begin
      pending_d[retire_rd] = 1'b0;
    end
    if (load[ISSUE_STAGE] && issue_rd_wr && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_en_q <= '0;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
    end else begin
      stage_en_q <= stage_en_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
    end
  end

  assign stage_en     = stage_en_q;
  assign stage_load   = load;
  assign pc           = pc_q;
  assign hazard_stall = hazard;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. Each stage holds an
//            instruction record; hazards are derived from which in-flight
//            instructions still owe a register write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int          N   = 4;
  localparam int          MW  = 32;
  localparam int          RC  = 32;
  localparam int          AW  = 5;
  localparam int          ISS = 2;
  localparam int          FL  = 2;
  localparam int          IB  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  stage_ready;
  logic [N-1:0]  stage_en;
  logic [N-1:0]  stage_load;
  logic [MW-1:0] pc;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd, retire_rd;
  logic [1:0]    issue_rs_used;
  logic          issue_rd_wr, retire_wr, flush, hazard_stall;
  logic [MW-1:0] flush_pc;

  pipe_ctrl #(
    .N_STAGES(N), .M_WIDTH(MW), .REG_CNT(RC), .REG_ADDR_WIDTH(AW),
    .ISSUE_STAGE(ISS), .FLUSH_STAGE(FL), .INST_BYTES(IB), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .stage_ready(stage_ready), .stage_en(stage_en),
    .stage_load(stage_load), .pc(pc), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_rd_wr(issue_rd_wr),
    .retire_rd(retire_rd), .retire_wr(retire_wr), .flush(flush), .flush_pc(flush_pc),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          wr;
    logic [1:0]  used;
  } instr_t;

  instr_t      slot [N];
  int          cnt  [N];
  logic [31:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t new_instr(input logic [31:0] a);
    instr_t t;
    t.v    = 1'b1;
    t.pc   = a;
    t.rd   = 5'($urandom_range(0, 7));
    t.rs1  = 5'($urandom_range(0, 7));
    t.rs2  = 5'($urandom_range(0, 7));
    t.wr   = 1'($urandom_range(0, 1));
    t.used = 2'($urandom_range(0, 3));
    return t;
  endfunction

  // Register r still owes a write from an issued instruction that is not
  // retiring this very cycle.
  function automatic bit reg_busy(input logic [4:0] r, input bit retiring);
    if (r == 5'd0) return 1'b0;
    for (int j = ISS; j < N; j++) begin
      if (slot[j].v && slot[j].wr && slot[j].rd == r && !(j == N - 1 && retiring))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      slot[k].v = 1'b0;
      slot[k].pc = '0; slot[k].rd = '0; slot[k].rs1 = '0; slot[k].rs2 = '0;
      slot[k].wr = 1'b0; slot[k].used = '0;
      cnt[k] = 0;
    end
    m_pc = RPC;
  endtask

  task automatic check_reset_outputs(input string ctx);
    check({ctx, "_stage_en"},   64'(stage_en),     64'(0));
    check({ctx, "_stage_load"}, 64'(stage_load),   64'(0));
    check({ctx, "_hazard"},     64'(hazard_stall), 64'(0));
    check({ctx, "_pc"},         64'(pc),           64'(RPC));
  endtask

  // One clock cycle: entered and left on a falling edge
  task automatic step(input int lat_max, input int flush_pct);
    bit           cmp [N];
    bit [N-1:0]   raw, ld, exp_en;
    bit           hz, ft, retiring;
    instr_t       nxt [N];

    for (int k = 0; k < N; k++)
      stage_ready[k] = slot[k].v ? (cnt[k] == 0) : ($urandom_range(0, 3) == 0);
    issue_rs1     = slot[ISS-1].rs1;
    issue_rs2     = slot[ISS-1].rs2;
    issue_rs_used = slot[ISS-1].used;
    issue_rd      = slot[ISS-1].rd;
    issue_rd_wr   = slot[ISS-1].wr;
    retire_rd     = slot[N-1].rd;
    retire_wr     = slot[N-1].wr;
    flush         = ($urandom_range(0, 99) < flush_pct);
    case ($urandom_range(0, 2))
      0:       flush_pc = 32'h0000_0100;
      1:       flush_pc = 32'hFFFF_FFFC;
      default: flush_pc = $urandom & 32'hFFFF_FFFC;
    endcase
    #1;

    for (int k = 0; k < N; k++) begin
      cmp[k]    = slot[k].v && stage_ready[k];
      exp_en[k] = slot[k].v;
    end
    retiring = cmp[N-1] && slot[N-1].wr && slot[N-1].rd != 5'd0;
    hz = cmp[ISS-1] &&
         ((slot[ISS-1].used[0] && reg_busy(slot[ISS-1].rs1, retiring)) ||
          (slot[ISS-1].used[1] && reg_busy(slot[ISS-1].rs2, retiring)) ||
          (slot[ISS-1].wr      && reg_busy(slot[ISS-1].rd,  retiring)));
    raw[0] = !slot[0].v && !stage_ready[0];
    for (int k = 1; k < N; k++)
      raw[k] = cmp[k-1] && !slot[k].v && !(k == ISS && hz);
    ft = flush && cmp[FL] && raw[FL+1];
    ld = raw;
    if (ft) for (int k = 0; k <= FL; k++) ld[k] = 1'b0;

    check("stage_en",     64'(stage_en),     64'(exp_en));
    check("stage_load",   64'(stage_load),   64'(ld));
    check("hazard_stall", 64'(hazard_stall), 64'(hz));
    check("pc",           64'(pc),           64'(m_pc));

    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (slot[k].v && cnt[k] > 0) cnt[k]--;
    nxt = slot;
    if (cmp[N-1]) nxt[N-1].v = 1'b0;
    for (int k = N - 1; k >= 1; k--) begin
      if (ld[k]) begin
        nxt[k]     = slot[k-1];
        nxt[k-1].v = 1'b0;
        cnt[k]     = $urandom_range(0, lat_max);
      end
    end
    if (ft) for (int k = 0; k < FL; k++) nxt[k].v = 1'b0;
    if (ld[0]) begin
      nxt[0] = new_instr(m_pc);
      cnt[0] = $urandom_range(0, lat_max);
    end
    // Fetch address: redirect target, else successor of the accepted fetch
    if (ft)         m_pc = flush_pc;
    else if (ld[1]) m_pc = slot[0].pc + 32'(IB);
    slot = nxt;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b0;
    stage_ready   = '0;
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_rs_used = '0;
    issue_rd      = '0;
    issue_rd_wr   = 1'b0;
    retire_rd     = '0;
    retire_wr     = 1'b0;
    flush         = 1'b0;
    flush_pc      = '0;
    clear_model();

    // Reset state; ready low would otherwise request a fetch
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Stages complete one cycle after enable, no redirects
    repeat (30) step(0, 0);
    // Variable stage latency exercises hazard stalls and bypass
    repeat (200) step(3, 0);
    // Redirects mixed in, including targets that wrap the PC
    repeat (300) step(3, 12);

    // Asynchronous reset in the middle of a redirect
    flush = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // Resume after reset: stale scoreboard bits would show up as stalls
    repeat (250) step(2, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
